// File: rtl/count_seq_ctrl_if.sv
// rtl/count_seq_ctrl_if.sv - button, count-control and counter-output bundle for count_seq_ctrl
interface count_seq_ctrl_if;
  logic        btn_start;
  logic        btn_pause;
  logic        btn_clear;
  logic        dir_down;
  logic [31:0] modulo;
  logic [31:0] num;
  logic        running;
  logic        tick;
  logic        wrap;

  modport master (
    output btn_start, btn_pause, btn_clear, dir_down, modulo,
    input  num, running, tick, wrap
  );

  modport slave (
    input  btn_start, btn_pause, btn_clear, dir_down, modulo,
    output num, running, tick, wrap
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - debounced run/pause/clear sequencer driving a modulo up/down counter
module count_seq_ctrl #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input logic             sys_clk,
  input logic             rst,
  count_seq_ctrl_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam int B_START = 0;
  localparam int B_PAUSE = 1;
  localparam int B_CLEAR = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    deb_q, deb_d, press_q, press_d;
  logic [DW-1:0] deb_cnt_q [3];
  logic [DW-1:0] deb_cnt_d [3];

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [31:0]   num_q, num_d;
  logic          running_q, running_d;
  logic          cmd_clear, cmd_pause, cmd_start;
  logic          tick_c, wrap_c;

  assign btn_raw = {bus.btn_clear, bus.btn_pause, bus.btn_start};

  // Debounce: a level change is accepted only after DEB_CYCLES consecutive mismatching samples.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
    press_d = deb_d & ~deb_q;
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    num_d     = num_q;
    tick_c    = 1'b0;
    wrap_c    = 1'b0;
    cmd_clear = press_q[B_CLEAR];
    cmd_pause = press_q[B_PAUSE] & ~press_q[B_CLEAR];
    cmd_start = press_q[B_START] & ~press_q[B_PAUSE] & ~press_q[B_CLEAR];

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          state_d = S_RUN;
          pre_d   = '0;
        end
      end
      S_RUN: begin
        // A pause in this cycle freezes the prescaler so resume continues from the same phase.
        if (cmd_pause) begin
          state_d = S_PAUSE;
        end else if (!cmd_clear) begin
          tick_c = (pre_q == PRE_MAX);
          pre_d  = tick_c ? '0 : pre_q + PW'(1);
          if (tick_c) begin
            if (!bus.dir_down) begin
              if (num_q >= bus.modulo) begin
                num_d  = '0;
                wrap_c = 1'b1;
              end else begin
                num_d = num_q + 32'd1;
              end
            end else begin
              if ((num_q == 32'd0) || (num_q > bus.modulo)) begin
                num_d  = bus.modulo;
                wrap_c = 1'b1;
              end else begin
                num_d = num_q - 32'd1;
              end
            end
          end
        end
      end
      S_PAUSE: begin
        if (cmd_start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_clear) begin
      state_d = S_IDLE;
      pre_d   = '0;
      num_d   = '0;
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      press_q   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      state_q   <= S_IDLE;
      pre_q     <= '0;
      num_q     <= '0;
      running_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      press_q   <= press_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      state_q   <= state_d;
      pre_q     <= pre_d;
      num_q     <= num_d;
      running_q <= running_d;
    end
  end

  assign bus.num     = num_q;
  assign bus.running = running_q;
  assign bus.tick    = tick_c;
  assign bus.wrap    = wrap_c;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - directed plus randomized check of count_seq_ctrl against a behavioural model
module tb_count_seq_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;

  logic sys_clk = 1'b0;
  logic rst;
  count_seq_ctrl_if bus();

  count_seq_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: run/paused flags, prescaler phase, count, per-button debounce view.
  bit          m_run, m_paused;
  int          m_pre;
  logic [31:0] m_num;
  bit          m_s1 [3];
  bit          m_s2 [3];
  bit          m_deb [3];
  int          m_streak [3];
  bit          m_press [3];
  bit          e_tick, e_wrap, e_clr, e_pau, e_sta;
  logic [31:0] e_next;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_paused = 0; m_pre = 0; m_num = 0;
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_streak[b] = 0; m_press[b] = 0;
    end
  endtask

  task automatic chk();
    e_clr  = m_press[2];
    e_pau  = m_press[1] && !e_clr;
    e_sta  = m_press[0] && !m_press[1] && !e_clr;
    e_tick = m_run && !e_pau && !e_clr && (m_pre == TD - 1);
    e_wrap = 0;
    e_next = m_num;
    if (e_tick) begin
      if (!bus.dir_down) begin
        if (m_num >= bus.modulo) begin e_next = 0; e_wrap = 1; end
        else e_next = m_num + 1;
      end else begin
        if (m_num == 0 || m_num > bus.modulo) begin e_next = bus.modulo; e_wrap = 1; end
        else e_next = m_num - 1;
      end
    end
    #1;
    check("num", bus.num, m_num);
    check("running", {31'd0, bus.running}, {31'd0, m_run});
    check("tick", {31'd0, bus.tick}, {31'd0, e_tick});
    check("wrap", {31'd0, bus.wrap}, {31'd0, e_wrap});
  endtask

  task automatic adv();
    logic [2:0] rv;
    rv = {bus.btn_clear, bus.btn_pause, bus.btn_start};
    if (e_clr) begin
      m_run = 0; m_paused = 0; m_num = 0; m_pre = 0;
    end else if (e_pau) begin
      if (m_run) begin m_run = 0; m_paused = 1; end
    end else if (e_sta && !m_run) begin
      if (!m_paused) m_pre = 0;
      m_run = 1; m_paused = 0;
    end else if (m_run) begin
      m_num = e_next;
      m_pre = (m_pre + 1) % TD;
    end
    for (int b = 0; b < 3; b++) begin
      m_press[b] = 0;
      if (m_s2[b] != m_deb[b]) begin
        m_streak[b]++;
        if (m_streak[b] == DB) begin
          m_deb[b] = m_s2[b];
          m_streak[b] = 0;
          m_press[b] = m_deb[b];
        end
      end else begin
        m_streak[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = rv[b];
    end
  endtask

  task automatic cyc();
    chk();
    adv();
    @(negedge sys_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_start = v;
      1: bus.btn_pause = v;
      default: bus.btn_clear = v;
    endcase
  endtask

  task automatic press(input int b, input int len);
    set_btn(b, 1'b1);
    run(len);
    set_btn(b, 1'b0);
  endtask

  task automatic wait_model(input logic [31:0] n, input int p, input int budget);
    int k;
    k = 0;
    while (!(m_run && m_num == n && m_pre == p) && k < budget) begin
      cyc();
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $error("FAIL wait_model: count %0d phase %0d not reached within %0d cycles", n, p, budget);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_start = 0; bus.btn_pause = 0; bus.btn_clear = 0;
    bus.dir_down = 0; bus.modulo = 32'd10;
    model_reset();
    @(negedge sys_clk);
    chk();
    @(negedge sys_clk);
    rst = 1'b0;

    // Start, then count 0..10 and wrap back to 0.
    press(0, 6);
    run(60);

    // Clear, then a 2-cycle glitch must not start; a 5-cycle hold must.
    press(2, 5);
    run(8);
    press(0, 2);
    run(12);
    press(0, 5);
    run(6);

    // Pause lands at count 5 / phase 2, then resume.
    press(2, 5);
    run(6);
    press(0, 5);
    wait_model(32'd4, 1, 200);
    press(1, 5);
    run(12);
    press(0, 5);
    run(12);

    // Clear and pause together at count 7 on a cycle that would tick.
    wait_model(32'd6, 2, 200);
    bus.btn_pause = 1; bus.btn_clear = 1;
    run(5);
    bus.btn_pause = 0; bus.btn_clear = 0;
    run(8);

    // Down count with modulo 3, then modulo 0.
    bus.dir_down = 1; bus.modulo = 32'd3;
    press(0, 5);
    run(26);
    bus.modulo = 32'd0;
    run(14);

    // Lower modulo below the current count while counting up.
    bus.dir_down = 0; bus.modulo = 32'd20;
    wait_model(32'd9, 0, 200);
    bus.modulo = 32'd4;
    run(10);

    // Random buttons, direction and modulo.
    for (int it = 0; it < 1200; it++) begin
      case ($urandom_range(0, 9))
        0: press($urandom_range(0, 2), $urandom_range(1, 7));
        1: press(0, $urandom_range(3, 6));
        2: bus.dir_down = $urandom_range(0, 1);
        3: bus.modulo = $urandom_range(0, 15);
        default: cyc();
      endcase
    end

    // Asynchronous reset in the middle of a count.
    bus.dir_down = 0; bus.modulo = 32'd10;
    press(2, 5);
    run(6);
    press(0, 5);
    run(11);
    #2;
    rst = 1'b1;
    model_reset();
    chk();
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    run(4);
    press(0, 5);
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
